eth_frame_tx: RTL and testbench
===============================

Name: eth_frame_tx

Overview:
Ethernet-style frame generator that drives the byte-wide receive stage. It buffers an outgoing payload in an internal FIFO, then on request emits one contiguous frame on `data`, with `start` aligned to the first preamble byte. Frame fields in order: preamble, SFD, destination MAC, source MAC, length, payload, FCS. The FCS is an 8-bit LRC. The output must never stall mid-frame, so transmission begins only once the whole payload is buffered.

Parameters:
- DEST_MAC_ADDR, 48'h00_0a_95_9d_68_16, destination MAC; sent least-significant byte first.
- SRC_MAC_ADDR, 48'h00_11_22_33_44_55, source MAC; sent least-significant byte first.
- DEPTH, 64, payload FIFO depth in bytes (power of 2); also the maximum payload length.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- pl_data  input  8  payload byte to buffer
- pl_vld  input  1  pl_data valid
- pl_rdy  output  1  FIFO can accept a byte
- send  input  1  request one frame (single-cycle pulse)
- len  input  16  payload length in bytes; sampled when send is accepted
- link_rdy  input  1  downstream receiver idle/ready
- data  output  8  frame byte stream
- start  output  1  first-byte marker
- busy  output  1  frame pending or in progress
- done  output  1  frame completed pulse
- err  output  1  request rejected pulse

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is asynchronous and active-high.
- In reset: FIFO empty, state IDLE, all outputs 0 (data=8'h00, start=0, busy=0, done=0, err=0, pl_rdy=0).
- After reset releases, pl_rdy follows the FIFO rule below.
- Reset mid-frame aborts immediately: FIFO flushed, nothing resumes.

FIFO:
- Push when pl_vld && pl_rdy; pop one byte per PL cycle.
- pl_rdy = (count < DEPTH), combinational from the count.
- Push and pop in the same cycle: count unchanged.
- Pushes are allowed in every state, including during transmission.
- Pointers wrap modulo DEPTH.

Request acceptance:
- send is accepted only in IDLE; len is latched into len_q.
- len > DEPTH: err pulses 1 cycle, state stays IDLE.
- send outside IDLE: ignored, no err.

States, each emitting one byte per cycle:
- IDLE: data=0, busy=0. An accepted send goes to WAIT.
- WAIT: busy=1, data=0. Leave when count >= len_q AND link_rdy=1; go to PREAMBLE on the next cycle.
- PREAMBLE: 7 cycles, data=8'hAA. start=1 on the first of these cycles only.
- SFD: 1 cycle, data=8'hAB.
- MACDST: 6 cycles; byte i (i = 0..5) = DEST_MAC_ADDR[i*8+:8].
- MACSRC: 6 cycles; byte i (i = 0..5) = SRC_MAC_ADDR[i*8+:8].
- PLLEN: 2 cycles, len_q[15:8] then len_q[7:0].
- PL: len_q cycles; data = FIFO head, popped the same cycle. len_q=0 skips PL entirely (PLLEN goes straight to FCS).
- FCS: 4 cycles; each byte = (~sum + 1) mod 256, where sum is the 8-bit wrapping sum of every byte emitted in MACDST, MACSRC, PLLEN and PL.
- DONE: 1 cycle; data=0, done=1, busy=0. Always returns to IDLE.

Timing and arithmetic:
- data and start are registered. The first preamble byte appears the cycle after the WAIT exit condition holds.
- A frame occupies exactly 26+len_q consecutive cycles with no gaps.
- sum clears on entering PREAMBLE and holds during FCS.
- The per-state byte counter is 16-bit, allowing PL up to 65535 cycles, although DEPTH bounds len in practice.
- link_rdy is checked only in WAIT; deassertion mid-frame has no effect.
- A send pulse in the DONE cycle is ignored; the next frame requires a send in IDLE.

Test Plan:
1. Reset, push 01 02 03, send with len=3, link_rdy=1:
   - data sequence: AA×7, AB, 16 68 9D 95 0A 00, 55 44 33 22 11 00, 00 03, 01 02 03, 3E×4.
   - 29 cycles total; start high on the first AA only; done pulses the cycle after the last 3E; FIFO count returns to 0.
2. len=0, FIFO empty, send:
   - 26-byte frame ending in length 00 00; FCS = (-(0x1BA+0xFF)) mod 256 = 0x47, sent ×4.
3. send with len=4 but only 2 bytes pushed:
   - busy=1 and data=0 while waiting; no start.
   - Push 2 more bytes: frame starts the cycle after count reaches 4.
4. FIFO filled to DEPTH=64:
   - pl_rdy=0; further pushes ignored.
   - Send len=64: all 64 bytes emitted in order; pl_rdy rises after the first pop.
   - Push during PL while full: count unchanged (simultaneous push/pop).
5. send with len=65:
   - err=1 for exactly 1 cycle; busy stays 0; no start.
   - send while busy is ignored without err.
6. link_rdy=0 at request:
   - Frame held in WAIT until link_rdy=1.
   - Assert rst during MACSRC: all outputs 0 asynchronously, FIFO empty, pl_rdy=1 after release.

Source files
------------

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: buffers a payload in a byte FIFO, then on request emits one
// contiguous Ethernet-style frame: preamble, SFD, destination MAC, source MAC,
// length, payload, 8-bit LRC FCS (sent four times).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pl_data/vld/rdy   payload byte push interface (rdy = FIFO not full)
//   send, len         one-cycle frame request; len sampled on acceptance
//   link_rdy          downstream ready, only consulted before a frame starts
//   data, start       registered frame byte stream and first-byte marker
//   busy, done, err   frame pending/active, frame-complete pulse, reject pulse
module eth_frame_tx #(
    parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
    parameter logic [47:0] SRC_MAC_ADDR  = 48'h00_11_22_33_44_55,
    parameter int unsigned DEPTH         = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pl_data,
    input  logic        pl_vld,
    output logic        pl_rdy,
    input  logic        send,
    input  logic [15:0] len,
    input  logic        link_rdy,
    output logic [7:0]  data,
    output logic        start,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [3:0] {
        StIdle, StWait, StPreamble, StSfd, StMacDst,
        StMacSrc, StPlLen, StPl, StFcs, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    len_q, len_d;
    logic [7:0]     sum_q, sum_d;
    logic [7:0]     data_q, data_d;
    logic           start_q, start_d;
    logic           err_q, err_d;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;
    logic [2:0]     idx;

    // ---------------- payload FIFO ----------------
    assign pl_rdy = ~rst & (count < CW'(DEPTH));
    assign push   = pl_vld & pl_rdy;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pl_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // ---------------- frame sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    // Next state and counter. The output byte is computed for the *next*
    // state/count so data is registered in step with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        len_d   = len_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (send) begin
                    if (len > 16'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = len;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = '0;
                if ((16'(count) >= len_q) && link_rdy) state_d = StPreamble;
            end
            StPreamble: if (cnt_q == 16'd6) begin state_d = StSfd;    cnt_d = '0; end
            StSfd:                          begin state_d = StMacDst; cnt_d = '0; end
            StMacDst:   if (cnt_q == 16'd5) begin state_d = StMacSrc; cnt_d = '0; end
            StMacSrc:   if (cnt_q == 16'd5) begin state_d = StPlLen;  cnt_d = '0; end
            StPlLen: begin
                if (cnt_q == 16'd1) begin
                    state_d = (len_q == 16'd0) ? StFcs : StPl;
                    cnt_d   = '0;
                end
            end
            StPl:       if (cnt_q == len_q - 16'd1) begin state_d = StFcs; cnt_d = '0; end
            StFcs:      if (cnt_q == 16'd3) begin state_d = StDone; cnt_d = '0; end
            StDone:                         begin state_d = StIdle; cnt_d = '0; end
            default:                        begin state_d = StIdle; cnt_d = '0; end
        endcase
    end

    assign idx = cnt_d[2:0];

    always_comb begin
        data_d  = 8'h00;
        start_d = 1'b0;
        pop     = 1'b0;
        sum_d   = sum_q;
        unique case (state_d)
            StPreamble: begin
                data_d  = 8'hAA;
                start_d = (state_q == StWait);
            end
            StSfd:    data_d = 8'hAB;
            StMacDst: data_d = DEST_MAC_ADDR[{idx, 3'b000} +: 8];
            StMacSrc: data_d = SRC_MAC_ADDR[{idx, 3'b000} +: 8];
            StPlLen:  data_d = cnt_d[0] ? len_q[7:0] : len_q[15:8];
            StPl: begin
                // Head byte is loaded into data and popped on the same edge.
                data_d = mem[rd_ptr];
                pop    = 1'b1;
            end
            StFcs:    data_d = (~sum_q) + 8'd1;
            default:  data_d = 8'h00;
        endcase
        if (state_d == StPreamble) begin
            sum_d = '0;
        end else if (state_d inside {StMacDst, StMacSrc, StPlLen, StPl}) begin
            sum_d = sum_q + data_d;
        end
    end

    assign data  = data_q;
    assign start = start_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: frames with hand-computed FCS values,
// wait-for-payload, full FIFO, rejected requests, link hold-off and reset abort.
module tb_eth_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pl_data;
    logic        pl_vld;
    logic        pl_rdy;
    logic        send;
    logic [15:0] len;
    logic        link_rdy;
    logic [7:0]  data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;

    int          nvec = 0;
    int          nerr = 0;
    int          mcount = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  pl_q [$];

    eth_frame_tx dut (
        .clk      (clk),
        .rst      (rst),
        .pl_data  (pl_data),
        .pl_vld   (pl_vld),
        .pl_rdy   (pl_rdy),
        .send     (send),
        .len      (len),
        .link_rdy (link_rdy),
        .data     (data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] b);
        pl_data = b;
        pl_vld  = 1'b1;
        tick();
        pl_vld  = 1'b0;
        if (mcount < 64) mcount++;
    endtask

    task automatic build(input logic [15:0] plen, input logic [7:0] fcs);
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h16); exp_q.push_back(8'h68); exp_q.push_back(8'h9D);
        exp_q.push_back(8'h95); exp_q.push_back(8'h0A); exp_q.push_back(8'h00);
        exp_q.push_back(8'h55); exp_q.push_back(8'h44); exp_q.push_back(8'h33);
        exp_q.push_back(8'h22); exp_q.push_back(8'h11); exp_q.push_back(8'h00);
        exp_q.push_back(plen[15:8]);
        exp_q.push_back(plen[7:0]);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs);
    endtask

    task automatic send_req(input logic [15:0] l);
        send = 1'b1;
        len  = l;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_start(input int max);
        int k = 0;
        while (start !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk("start_seen", start, 1);
    endtask

    // Walks ncheck frame cycles; optionally pushes 0x77 at frame index push_at.
    task automatic check_frame(input int ncheck, input int plen, input int push_at);
        bit pushed;
        for (int i = 0; i < ncheck; i++) begin
            chk("data", data, exp_q[i]);
            chk("start", start, (i == 0));
            chk("busy", busy, 1);
            chk("pl_rdy", pl_rdy, (mcount < 64));
            pushed = (i == push_at) && (mcount < 64);
            if (i == push_at) begin
                pl_vld  = 1'b1;
                pl_data = 8'h77;
            end
            tick();
            pl_vld = 1'b0;
            if (pushed) mcount++;
            if (i + 1 >= 22 && i + 1 < 22 + plen) mcount--;
            chk("count", dut.count, mcount);
        end
    endtask

    task automatic check_done();
        chk("done_hi", done, 1);
        chk("done_busy", busy, 0);
        chk("done_data", data, 0);
        tick();
        chk("done_lo", done, 0);
    endtask

    initial begin
        rst = 1'b1; pl_data = 8'h00; pl_vld = 1'b0; send = 1'b0; len = 16'd0;
        link_rdy = 1'b1;
        tick(); tick();
        chk("rst_data", data, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pl_rdy", pl_rdy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_pl_rdy", pl_rdy, 1);
        chk("post_rst_count", dut.count, 0);

        // Frame with payload 01 02 03
        push(8'h01); push(8'h02); push(8'h03);
        chk("t1_count", dut.count, 3);
        send_req(16'd3);
        chk("t1_wait_busy", busy, 1);
        chk("t1_wait_start", start, 0);
        wait_start(4);
        pl_q = {8'h01, 8'h02, 8'h03};
        build(16'd3, 8'h3E);
        check_frame(29, 3, -1);
        // send in the DONE cycle must be ignored
        chk("t1_done", done, 1);
        chk("t1_done_data", data, 0);
        send = 1'b1; len = 16'd0;
        tick();
        send = 1'b0;
        chk("t1_idle_busy", busy, 0);
        tick();
        chk("t1_ignored_busy", busy, 0);
        chk("t1_ignored_start", start, 0);
        chk("t1_count_end", dut.count, 0);

        // Empty payload
        send_req(16'd0);
        wait_start(4);
        pl_q = {};
        build(16'd0, 8'h47);
        check_frame(26, 0, -1);
        check_done();

        // Request waits for payload
        push(8'h10); push(8'h20);
        send_req(16'd4);
        for (int i = 0; i < 3; i++) begin
            chk("t3_wait_busy", busy, 1);
            chk("t3_wait_data", data, 0);
            chk("t3_wait_start", start, 0);
            tick();
        end
        push(8'h30);
        chk("t3_start3", start, 0);
        push(8'h40);
        chk("t3_start4", start, 0);
        tick();
        pl_q = {8'h10, 8'h20, 8'h30, 8'h40};
        build(16'd4, 8'hA3);
        check_frame(30, 4, -1);
        check_done();

        // Full FIFO
        pl_q = {};
        for (int i = 0; i < 64; i++) begin
            push(8'(i));
            pl_q.push_back(8'(i));
        end
        chk("t4_full_rdy", pl_rdy, 0);
        push(8'hFF);
        chk("t4_full_count", dut.count, 64);
        send_req(16'd64);
        wait_start(4);
        build(16'd64, 8'h27);
        check_frame(90, 64, 30);
        check_done();
        chk("t4_leftover", dut.count, 1);

        // Oversize request rejected
        send_req(16'd65);
        chk("t5_err_hi", err, 1);
        chk("t5_err_busy", busy, 0);
        tick();
        chk("t5_err_lo", err, 0);
        chk("t5_busy_lo", busy, 0);
        chk("t5_no_start", start, 0);

        // Link hold-off, send while busy, reset mid-frame
        link_rdy = 1'b0;
        send_req(16'd1);
        chk("t6_wait_busy", busy, 1);
        send_req(16'd65);
        chk("t6_busy_send_err", err, 0);
        chk("t6_busy_send_busy", busy, 1);
        tick(); tick();
        chk("t6_held_start", start, 0);
        chk("t6_held_data", data, 0);
        link_rdy = 1'b1;
        wait_start(4);
        link_rdy = 1'b0;
        pl_q = {8'h77};
        build(16'd1, 8'hCF);
        check_frame(16, 1, -1);
        chk("t6_macsrc_data", data, 8'h33);
        rst = 1'b1;
        #1;
        mcount = 0;
        chk("t6_rst_data", data, 0);
        chk("t6_rst_start", start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_pl_rdy", pl_rdy, 0);
        chk("t6_rst_count", dut.count, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rel_pl_rdy", pl_rdy, 1);
        tick();
        chk("t6_rel_busy", busy, 0);
        chk("t6_rel_data", data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
